// File: rtl/tc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e   : FETCH (reading ROM words) / HOLD (instruction presented)
//   DEF_*           : default geometry of the fetch path
//   INSTR_WIDTH     : bits in one assembled instruction at the default geometry
//   word_idx_width  : width of the word-index counter, never narrower than 1 bit
package tc_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam int DEF_ROM_WIDTH   = 8;
    localparam int DEF_INSTR_WORDS = 4;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH     = DEF_INSTR_WORDS * DEF_ROM_WIDTH;

    function automatic int word_idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/tc_instr_assembler.sv
// Collects consecutive ROM words into one instruction register.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears index and register)
//   clr_i           : restart assembly at word 0; stored words are left as they are
//   wr_en_i         : store wr_data_i at the current index and advance the index
//   wr_data_i       : one ROM word
//   word_idx_o      : index the next write goes to
//   last_o          : next write completes the instruction
//   instr_o         : assembled instruction, word 0 in the LSBs
module tc_instr_assembler
    import tc_fetch_pkg::*;
#(
    parameter int ROM_WIDTH   = DEF_ROM_WIDTH,
    parameter int INSTR_WORDS = DEF_INSTR_WORDS,
    localparam int IDX_W      = word_idx_width(INSTR_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             wr_en_i,
    input  logic [ROM_WIDTH-1:0]             wr_data_i,
    output logic [IDX_W-1:0]                 word_idx_o,
    output logic                             last_o,
    output logic [INSTR_WORDS*ROM_WIDTH-1:0] instr_o
);

    logic [IDX_W-1:0] word_idx_q;
    logic [IDX_W-1:0] word_idx_d;
    logic             wr_ok;

    // clr beats a write so a flushed cycle can never land a word.
    assign wr_ok  = wr_en_i && !clr_i;
    assign last_o = (word_idx_q == IDX_W'(INSTR_WORDS - 1));

    always_comb begin
        word_idx_d = word_idx_q;
        if (clr_i) begin
            word_idx_d = '0;
        end else if (wr_en_i) begin
            word_idx_d = last_o ? '0 : word_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_q <= '0;
        end else begin
            word_idx_q <= word_idx_d;
        end
    end

    // One register slice per word, each loaded only when the index selects it.
    for (genvar gi = 0; gi < INSTR_WORDS; gi++) begin : g_word
        logic [ROM_WIDTH-1:0] word_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
            end else if (wr_ok && (word_idx_q == IDX_W'(gi))) begin
                word_q <= wr_data_i;
            end
        end

        assign instr_o[gi*ROM_WIDTH +: ROM_WIDTH] = word_q;
    end

    assign word_idx_o = word_idx_q;

endmodule

// File: rtl/tc_fetch_unit.sv
// Instruction fetch stage sitting directly behind the program ROM.
// Reads INSTR_WORDS consecutive ROM words, presents the assembled instruction
// to the decoder with valid/ready, and follows branch redirects from execute.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : fetch enable (only matters while fetching)
//   rom_load, rom_address    : ROM read strobe and word address
//   rom_data                 : combinational ROM output for rom_address
//   redirect, redirect_pc    : flush and restart fetching at redirect_pc
//   instr_valid, instr_ready : decoder handshake
//   instr, instr_pc          : assembled instruction and address of its first word
//   fetch_pc                 : current fetch pointer
module tc_fetch_unit
    import tc_fetch_pkg::*;
#(
    parameter int                    ROM_WIDTH   = DEF_ROM_WIDTH,
    parameter int                    INSTR_WORDS = DEF_INSTR_WORDS,
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    output logic                             rom_load,
    output logic [ADDR_WIDTH-1:0]            rom_address,
    input  logic [ROM_WIDTH-1:0]             rom_data,
    input  logic                             redirect,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc,
    output logic                             instr_valid,
    input  logic                             instr_ready,
    output logic [INSTR_WORDS*ROM_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]            instr_pc,
    output logic [ADDR_WIDTH-1:0]            fetch_pc
);

    localparam int IDX_W = word_idx_width(INSTR_WORDS);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] fetch_ptr_q;
    logic [ADDR_WIDTH-1:0] fetch_ptr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic                  instr_valid_q;
    logic [IDX_W-1:0]      word_idx;
    logic                  word_last;

    // A redirect cycle never reads: the address it would read is about to be abandoned.
    assign rom_load    = (state_q == FETCH) && en && !redirect && !rst;
    assign rom_address = fetch_ptr_q;
    assign fetch_pc    = fetch_ptr_q;
    // Natural overflow gives the modulo-2^ADDR_WIDTH wrap.
    assign fetch_ptr_d = fetch_ptr_q + ADDR_WIDTH'(1);

    tc_instr_assembler #(
        .ROM_WIDTH   (ROM_WIDTH),
        .INSTR_WORDS (INSTR_WORDS)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (redirect),
        .wr_en_i    (rom_load),
        .wr_data_i  (rom_data),
        .word_idx_o (word_idx),
        .last_o     (word_last),
        .instr_o    (instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_ptr_q   <= RESET_PC;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else if (redirect) begin
            // A transfer accepted in this same cycle has already been taken by the
            // decoder; dropping valid here is all that is needed either way.
            state_q       <= FETCH;
            fetch_ptr_q   <= redirect_pc;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (rom_load) begin
                        fetch_ptr_q <= fetch_ptr_d;
                        if (word_idx == '0) begin
                            instr_pc_q <= fetch_ptr_q;
                        end
                        if (word_last) begin
                            state_q       <= HOLD;
                            instr_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (instr_valid_q && instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH;
                    end
                end
            endcase
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_tc_fetch_unit.sv
module tb_tc_fetch_unit;

    localparam int RW = 8;
    localparam int IW = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rom_load;
    logic [AW-1:0] rom_address;
    logic [RW-1:0] rom_data;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW*RW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] fetch_pc;

    logic [RW-1:0] rom [0:65535];

    int errors = 0;
    int checks = 0;

    assign rom_data = rom[rom_address];

    always #5 clk = ~clk;

    tc_fetch_unit #(
        .ROM_WIDTH   (RW),
        .INSTR_WORDS (IW),
        .ADDR_WIDTH  (AW),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rom_load    (rom_load),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_pc    (fetch_pc)
    );

    // Reference: an instruction at pc is the IW ROM words starting at pc,
    // addresses wrapping at 2^AW, word 0 in the LSBs.
    function automatic logic [IW*RW-1:0] expected_instr(input logic [AW-1:0] pc);
        logic [IW*RW-1:0] r;
        logic [AW-1:0]    a;
        r = '0;
        for (int k = 0; k < IW; k++) begin
            a = pc + AW'(k);
            r[k*RW +: RW] = rom[a];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until instr_valid is seen, or -1 on timeout.
    task automatic wait_valid(input int limit, output int cycles);
        cycles = -1;
        for (int c = 1; c <= limit && cycles < 0; c++) begin
            tick();
            if (instr_valid === 1'b1) cycles = c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        tick(); tick();
        checks++; if (rom_load !== 1'b0) begin errors++; $display("FAIL reset_rom_load: got %b want 0", rom_load); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== '0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        checks++; if (fetch_pc !== '0) begin errors++; $display("FAIL reset_fetch_pc: got %h want 0", fetch_pc); end
        $display("reset: valid=%b fetch_pc=%h rom_load=%b", instr_valid, fetch_pc, rom_load);
    endtask

    task automatic test_basic;
        int cyc;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        instr_ready = 1'b1;
        rst = 1'b0;
        wait_valid(20, cyc);
        checks++; if (cyc !== IW) begin errors++; $display("FAIL first_latency: got %0d want %0d", cyc, IW); end
        checks++; if (instr !== 32'h44332211) begin errors++; $display("FAIL first_instr: got %h want 44332211", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL first_instr_pc: got %h want 0000", instr_pc); end
        checks++; if (fetch_pc !== 16'h0004) begin errors++; $display("FAIL first_fetch_pc: got %h want 0004", fetch_pc); end
        checks++; if (rom_load !== 1'b0) begin errors++; $display("FAIL hold_rom_load: got %b want 0", rom_load); end
        $display("basic: instr=%h pc=%h after %0d cycles", instr, instr_pc, cyc);
        wait_valid(20, cyc);
        checks++; if (cyc !== IW + 1) begin errors++; $display("FAIL back_to_back_spacing: got %0d want %0d", cyc, IW + 1); end
        checks++; if (instr_pc !== 16'h0004) begin errors++; $display("FAIL second_instr_pc: got %h want 0004", instr_pc); end
        checks++; if (instr !== expected_instr(16'h0004)) begin errors++; $display("FAIL second_instr: got %h want %h", instr, expected_instr(16'h0004)); end
        $display("back_to_back: instr=%h pc=%h spacing=%0d", instr, instr_pc, cyc);
        instr_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [IW*RW-1:0] exp_i;
        exp_i = expected_instr(16'h0004);
        for (int i = 0; i < 5; i++) begin
            en = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
            checks++; if (instr !== exp_i) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, exp_i); end
            checks++; if (instr_pc !== 16'h0004) begin errors++; $display("FAIL stall_instr_pc[%0d]: got %h want 0004", i, instr_pc); end
            checks++; if (rom_load !== 1'b0) begin errors++; $display("FAIL stall_rom_load[%0d]: got %b want 0", i, rom_load); end
            checks++; if (fetch_pc !== 16'h0008) begin errors++; $display("FAIL stall_fetch_pc[%0d]: got %h want 0008", i, fetch_pc); end
            $display("stall %0d: valid=%b instr=%h fetch_pc=%h", i, instr_valid, instr, fetch_pc);
        end
        en = 1'b1;
        instr_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect;
        int cyc;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 16'h0010;
        #1;
        checks++; if (rom_load !== 1'b0) begin errors++; $display("FAIL redirect_rom_load: got %b want 0", rom_load); end
        tick();
        redirect = 1'b0;
        checks++; if (fetch_pc !== 16'h0010) begin errors++; $display("FAIL redirect_fetch_pc: got %h want 0010", fetch_pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid: got %b want 0", instr_valid); end
        wait_valid(20, cyc);
        checks++; if (cyc !== IW) begin errors++; $display("FAIL redirect_latency: got %0d want %0d", cyc, IW); end
        checks++; if (instr_pc !== 16'h0010) begin errors++; $display("FAIL redirect_instr_pc: got %h want 0010", instr_pc); end
        checks++; if (instr !== expected_instr(16'h0010)) begin errors++; $display("FAIL redirect_instr: got %h want %h", instr, expected_instr(16'h0010)); end
        $display("redirect: instr=%h pc=%h", instr, instr_pc);
    endtask

    task automatic test_wrap;
        int cyc;
        rom[16'hFFFE] = 8'hAA; rom[16'hFFFF] = 8'hBB; rom[16'h0000] = 8'hCC; rom[16'h0001] = 8'hDD;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        wait_valid(20, cyc);
        checks++; if (cyc !== IW) begin errors++; $display("FAIL wrap_latency: got %0d want %0d", cyc, IW); end
        checks++; if (instr !== 32'hDDCCBBAA) begin errors++; $display("FAIL wrap_instr: got %h want ddccbbaa", instr); end
        checks++; if (instr_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_instr_pc: got %h want fffe", instr_pc); end
        checks++; if (fetch_pc !== 16'h0002) begin errors++; $display("FAIL wrap_fetch_pc: got %h want 0002", fetch_pc); end
        $display("wrap: instr=%h pc=%h fetch_pc=%h", instr, instr_pc, fetch_pc);
    endtask

    task automatic test_en_toggle;
        int n;
        int extra;
        int i;
        logic [AW-1:0] exp_fp;
        logic fixed_pat [4];
        fixed_pat[0] = 1'b1; fixed_pat[1] = 1'b0; fixed_pat[2] = 1'b0; fixed_pat[3] = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        n = 0; extra = 0; i = 0;
        while ((n < IW || extra < 3) && i < 60) begin
            en = (i < 4) ? fixed_pat[i] : 1'($urandom_range(0, 1));
            if (en && n < IW) n++;
            else if (n >= IW) extra++;
            tick();
            exp_fp = 16'h0020 + AW'(n);
            checks++; if (instr_valid !== (n >= IW)) begin errors++; $display("FAIL en_toggle_valid[%0d]: got %b want %b", i, instr_valid, n >= IW); end
            checks++; if (fetch_pc !== exp_fp) begin errors++; $display("FAIL en_toggle_fetch_pc[%0d]: got %h want %h", i, fetch_pc, exp_fp); end
            $display("en_toggle %0d: en=%b words=%0d fetch_pc=%h valid=%b", i, en, n, fetch_pc, instr_valid);
            i++;
        end
        checks++; if (instr !== expected_instr(16'h0020)) begin errors++; $display("FAIL en_toggle_instr: got %h want %h", instr, expected_instr(16'h0020)); end
        checks++; if (instr_pc !== 16'h0020) begin errors++; $display("FAIL en_toggle_instr_pc: got %h want 0020", instr_pc); end
        en = 1'b1;
    endtask

    task automatic test_redirect_handshake;
        instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0; instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_hs_valid: got %b want 0", instr_valid); end
        checks++; if (fetch_pc !== 16'h0100) begin errors++; $display("FAIL redir_hs_fetch_pc: got %h want 0100", fetch_pc); end
        $display("redirect_handshake: valid=%b fetch_pc=%h", instr_valid, fetch_pc);
    endtask

    task automatic test_random_stream;
        logic [AW-1:0] exp_pc;
        int handshakes;
        exp_pc = 16'h0100;
        handshakes = 0;
        for (int i = 0; i < 600; i++) begin
            en          = ($urandom_range(0, 3) != 0);
            instr_ready = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = AW'($urandom);
            #1;
            if (redirect || instr_valid) begin
                checks++; if (rom_load !== 1'b0) begin errors++; $display("FAIL rand_rom_load[%0d]: got %b want 0", i, rom_load); end
            end
            if (instr_valid === 1'b1 && instr_ready) begin
                checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL rand_instr_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
                checks++; if (instr !== expected_instr(exp_pc)) begin errors++; $display("FAIL rand_instr[%0d]: got %h want %h", i, instr, expected_instr(exp_pc)); end
                $display("rand %0d: take pc=%h instr=%h", i, instr_pc, instr);
                exp_pc = exp_pc + AW'(IW);
                handshakes++;
            end
            if (redirect) begin
                exp_pc = redirect_pc;
                $display("rand %0d: redirect to %h", i, redirect_pc);
            end
            tick();
        end
        redirect = 1'b0;
        checks++; if (handshakes < 10) begin errors++; $display("FAIL rand_handshakes: got %0d want >=10", handshakes); end
    endtask

    task automatic test_rst_in_hold;
        int cyc;
        en = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
        wait_valid(40, cyc);
        checks++; if (cyc < 1) begin errors++; $display("FAIL rst_hold_reach: got %0d want >=1", cyc); end
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", instr_valid); end
        checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL rst_hold_fetch_pc: got %h want 0000", fetch_pc); end
        checks++; if (instr !== '0) begin errors++; $display("FAIL rst_hold_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL rst_hold_instr_pc: got %h want 0", instr_pc); end
        $display("rst_in_hold: valid=%b fetch_pc=%h", instr_valid, fetch_pc);
        wait_valid(20, cyc);
        checks++; if (cyc !== IW) begin errors++; $display("FAIL rst_hold_latency: got %0d want %0d", cyc, IW); end
        checks++; if (instr !== expected_instr(16'h0000)) begin errors++; $display("FAIL rst_hold_refetch: got %h want %h", instr, expected_instr(16'h0000)); end
        $display("rst_in_hold refetch: instr=%h pc=%h", instr, instr_pc);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = RW'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_en_toggle();
        test_redirect_handshake();
        test_random_stream();
        test_rst_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
